// File: rtl/viking_pkg.sv
// rtl/viking_pkg.sv - shared constants, state type and address helper for the Viking fetch path
//
// Contents:
//   VIDEO_AW, RAM_DW, GROUP_WORDS, DATA_W : bus widths of the video and RAM sides
//   BASE, BASE_HI                         : Viking framebuffer base constants
//   fetch_state_t                         : responder FSM states
//   group_addr()                          : RAM word address inside a 4-word group
package viking_pkg;

    localparam int VIDEO_AW    = 23;
    localparam int RAM_DW      = 16;
    localparam int GROUP_WORDS = 4;
    localparam int DATA_W      = RAM_DW * GROUP_WORDS;

    localparam logic [VIDEO_AW-1:0] BASE    = 23'h600000;
    localparam logic [VIDEO_AW-1:0] BASE_HI = 23'h740000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_COMMIT = 2'd2
    } fetch_state_t;

    // The word index is concatenated, not added, so a group never carries
    // into its neighbour (7FFFFC..7FFFFF stays put, no wrap to 0).
    function automatic logic [VIDEO_AW-1:0] group_addr(
        input logic [VIDEO_AW-3:0] grp,
        input logic [1:0]          k
    );
        return {grp, k};
    endfunction

endpackage

// File: rtl/viking_fetch_responder_if.sv
// rtl/viking_fetch_responder_if.sv - 16-bit req/ack RAM word port
//
// Signals:
//   ram_req  : responder -> RAM, word request
//   ram_addr : responder -> RAM, word address
//   ram_ack  : RAM -> responder, word valid this cycle
//   ram_data : RAM -> responder, word data
// Modports: master (responder side), slave (RAM controller side)
interface viking_fetch_responder_if;
    import viking_pkg::*;

    logic                ram_req;
    logic [VIDEO_AW-1:0] ram_addr;
    logic                ram_ack;
    logic [RAM_DW-1:0]   ram_data;

    modport master (
        output ram_req,
        output ram_addr,
        input  ram_ack,
        input  ram_data
    );

    modport slave (
        input  ram_req,
        input  ram_addr,
        output ram_ack,
        output ram_data
    );

endinterface

// File: rtl/viking_fetch_responder_word_assembler.sv
// rtl/viking_fetch_responder_word_assembler.sv - staging register and atomic commit of a 64-bit video word
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_wr_en        : write i_word into staging slot i_slot
//   i_slot         : word index 0..3 (slot k occupies bits 16k+15:16k)
//   i_word         : RAM word
//   i_commit       : copy the whole staging register to o_data
//   o_data         : committed 64-bit word, holds until the next commit
module viking_fetch_responder_word_assembler
    import viking_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [1:0]        i_slot,
    input  logic [RAM_DW-1:0] i_word,
    input  logic              i_commit,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_stage;
    logic [DATA_W-1:0] r_data;

    // The video bus only ever sees r_data, so a half-filled group is never visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage <= '0;
            r_data  <= '0;
        end else begin
            if (i_wr_en) begin
                r_stage[32'(i_slot) * RAM_DW +: RAM_DW] <= i_word;
            end
            if (i_commit) begin
                r_data <= r_stage;
            end
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/viking_fetch_responder.sv
// rtl/viking_fetch_responder.sv - fetches a 4-word RAM group per video read strobe and presents it as one 64-bit word
//
// Parameters:
//   DEADLINE  : mclk cycles after acceptance by which the commit is due
// Ports:
//   mclk      : memory clock
//   reset_n   : asynchronous active-low reset
//   bus_cycle : current bus slot (informational)
//   read      : video read strobe, rising edge starts a fetch
//   addr      : video word address, addr[1:0] ignored
//   ram       : RAM word port (master modport)
//   data      : assembled 64-bit video data
//   busy      : fetch in progress
//   late      : one-cycle pulse when a commit misses DEADLINE
module viking_fetch_responder
    import viking_pkg::*;
#(
    parameter int DEADLINE = 12
) (
    input  logic                mclk,
    input  logic                reset_n,
    input  logic [1:0]          bus_cycle,
    input  logic                read,
    input  logic [VIDEO_AW-1:0] addr,
    viking_fetch_responder_if.master ram,
    output logic [DATA_W-1:0]   data,
    output logic                busy,
    output logic                late
);

    fetch_state_t        r_state;
    logic                r_read_d;
    logic [VIDEO_AW-3:0] r_base;
    logic [1:0]          r_k;
    logic [4:0]          r_timer;
    logic                r_ram_req;
    logic [VIDEO_AW-1:0] r_ram_addr;
    logic                r_busy;
    logic                r_late;

    logic w_ack;
    logic w_wr_en;
    logic w_commit;
    logic w_unused;

    // Acks outside an outstanding request are stray and must not move the FSM.
    assign w_ack    = ram.ram_ack && r_ram_req;
    assign w_wr_en  = (r_state == ST_FETCH) && w_ack;
    assign w_commit = (r_state == ST_COMMIT);
    assign w_unused = ^{bus_cycle, addr[1:0]};

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_read_d   <= 1'b0;
            r_base     <= '0;
            r_k        <= 2'd0;
            r_timer    <= 5'd0;
            r_ram_req  <= 1'b0;
            r_ram_addr <= '0;
            r_busy     <= 1'b0;
            r_late     <= 1'b0;
        end else begin
            // read_d follows read in every state, so a level held across a
            // fetch is not seen as a new edge once the FSM is back in IDLE.
            r_read_d <= read;
            r_late   <= 1'b0;

            if (r_state != ST_IDLE && r_timer != 5'h1F) begin
                r_timer <= r_timer + 5'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (read && !r_read_d) begin
                        r_base     <= addr[VIDEO_AW-1:2];
                        r_k        <= 2'd0;
                        r_timer    <= 5'd0;
                        r_ram_req  <= 1'b1;
                        r_ram_addr <= group_addr(addr[VIDEO_AW-1:2], 2'd0);
                        r_busy     <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (w_ack) begin
                        if (r_k == 2'd3) begin
                            r_ram_req <= 1'b0;
                            r_state   <= ST_COMMIT;
                        end else begin
                            r_k        <= r_k + 2'd1;
                            r_ram_addr <= group_addr(r_base, r_k + 2'd1);
                        end
                    end
                end

                ST_COMMIT: begin
                    r_late  <= (int'(r_timer) > DEADLINE);
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_ram_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    viking_fetch_responder_word_assembler u_assembler (
        .i_clk    (mclk),
        .i_rst_n  (reset_n),
        .i_wr_en  (w_wr_en),
        .i_slot   (r_k),
        .i_word   (ram.ram_data),
        .i_commit (w_commit),
        .o_data   (data)
    );

    assign ram.ram_req  = r_ram_req;
    assign ram.ram_addr = r_ram_addr;
    assign busy         = r_busy;
    assign late         = r_late;

endmodule

// File: tb/tb_viking_fetch_responder.sv
// tb/tb_viking_fetch_responder.sv - table-driven and sequence checks of viking_fetch_responder
module tb_viking_fetch_responder;
    import viking_pkg::*;

    logic        mclk      = 1'b0;
    logic        reset_n   = 1'b0;
    logic [1:0]  bus_cycle = 2'd0;
    logic        read      = 1'b0;
    logic [22:0] addr      = 23'd0;
    logic [63:0] data;
    logic        busy;
    logic        late;

    viking_fetch_responder_if ram_if ();

    viking_fetch_responder #(.DEADLINE(12)) dut (
        .mclk      (mclk),
        .reset_n   (reset_n),
        .bus_cycle (bus_cycle),
        .read      (read),
        .addr      (addr),
        .ram       (ram_if),
        .data      (data),
        .busy      (busy),
        .late      (late)
    );

    always #5 mclk = ~mclk;

    int total = 0;
    int bad   = 0;

    // RAM model controls and monitor counters
    int          ram_wait = 0;
    logic [15:0] ram_pat  = 16'h0000;
    bit          stray    = 1'b0;
    bit          req_q    = 1'b0;
    bit          ack_v    = 1'b0;
    int          wcnt     = 0;

    logic [22:0] ack_log[$];
    int          busy_rises = 0;
    int          late_cnt   = 0;
    int          busy_cyc   = 0;
    int          hold_bad   = 0;
    logic        busy_q     = 1'b0;
    logic [63:0] data_q     = 64'd0;

    // Monitor then RAM model, both on the falling edge.  RAM acks one cycle
    // after a request first appears, then after ram_wait extra cycles per word;
    // the word returned is ram_addr[15:0] ^ ram_pat.
    initial begin
        ram_if.ram_ack  = 1'b0;
        ram_if.ram_data = 16'h0000;
        forever begin
            @(negedge mclk);
            if (busy && !busy_q) busy_rises++;
            if (busy) busy_cyc++;
            if (late) late_cnt++;
            if (busy && data !== data_q) hold_bad++;
            busy_q = busy;
            data_q = data;

            if (ram_if.ram_req && req_q) begin
                if (wcnt < ram_wait) begin
                    ack_v = 1'b0;
                    wcnt++;
                end else begin
                    ack_v = 1'b1;
                    wcnt  = 0;
                    ack_log.push_back(ram_if.ram_addr);
                end
            end else begin
                ack_v = 1'b0;
                wcnt  = 0;
            end
            ram_if.ram_ack  = ack_v | stray;
            ram_if.ram_data = ram_if.ram_addr[15:0] ^ ram_pat;
            req_q = ram_if.ram_req;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge mclk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        ack_log.delete();
        busy_rises = 0;
        late_cnt   = 0;
        busy_cyc   = 0;
        hold_bad   = 0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        chk({nm, "_idle_timeout"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic chk_group(input string nm, input logic [22:0] base);
        chk({nm, "_ack_count"}, 64'(ack_log.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < ack_log.size())
                chk($sformatf("%s_addr%0d", nm, k), {41'd0, ack_log[k]}, {41'd0, base + 23'(k)});
        end
    endtask

    typedef struct {
        logic [22:0] addr;
        int          wt;
        logic [15:0] pat;
        int          hold;
        logic [22:0] exp_base;
        logic [63:0] exp_data;
        logic        exp_late;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{23'h600000, 0, 16'h1000,  1, 23'h600000, 64'h1003_1002_1001_1000, 1'b0,  6};
        vecs[1] = '{23'h600006, 0, 16'h0000, 10, 23'h600004, 64'h0007_0006_0005_0004, 1'b0,  6};
        vecs[2] = '{23'h7FFFFC, 0, 16'h0000,  1, 23'h7FFFFC, 64'hFFFF_FFFE_FFFD_FFFC, 1'b0,  6};
        vecs[3] = '{23'h600000, 3, 16'hBEE0,  1, 23'h600000, 64'hBEE3_BEE2_BEE1_BEE0, 1'b1, 18};
        vecs[4] = '{23'h740001, 1, 16'h5500,  2, 23'h740000, 64'h5503_5502_5501_5500, 1'b0, 10};
        vecs[5] = '{23'h600008, 2, 16'h0000,  1, 23'h600008, 64'h000B_000A_0009_0008, 1'b1, 14};

        // reset state
        tick(2);
        chk("rst_ram_req",  {63'd0, ram_if.ram_req}, 64'd0);
        chk("rst_ram_addr", {41'd0, ram_if.ram_addr}, 64'd0);
        chk("rst_data",     data, 64'd0);
        chk("rst_busy",     {63'd0, busy}, 64'd0);
        chk("rst_late",     {63'd0, late}, 64'd0);
        reset_n = 1'b1;
        tick(2);

        // table-driven single fetches
        for (int i = 0; i < 6; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            clear_mon();
            addr     = vecs[i].addr;
            ram_wait = vecs[i].wt;
            ram_pat  = vecs[i].pat;
            read     = 1'b1;
            tick(vecs[i].hold);
            read     = 1'b0;
            wait_idle(nm, 100);
            tick(3);
            chk_group(nm, vecs[i].exp_base);
            chk({nm, "_data"},    data, vecs[i].exp_data);
            chk({nm, "_late"},    64'(late_cnt), {63'd0, vecs[i].exp_late});
            chk({nm, "_fetches"}, 64'(busy_rises), 64'd1);
            chk({nm, "_latency"}, 64'(busy_cyc), 64'(vecs[i].exp_lat));
            chk({nm, "_hold"},    64'(hold_bad), 64'd0);
        end

        // second rising read during FETCH is ignored
        clear_mon();
        ram_wait = 0;
        ram_pat  = 16'h0000;
        addr     = 23'h600010;
        read = 1'b1; tick(1);
        read = 1'b0; tick(1);
        read = 1'b1; tick(1);
        read = 1'b0;
        wait_idle("refire", 100);
        tick(2);
        chk_group("refire", 23'h600010);
        chk("refire_fetches", 64'(busy_rises), 64'd1);
        chk("refire_data", data, 64'h0013_0012_0011_0010);

        // next strobe fetches the following group
        clear_mon();
        addr = 23'h600014;
        read = 1'b1; tick(1);
        read = 1'b0;
        wait_idle("next", 100);
        tick(2);
        chk_group("next", 23'h600014);
        chk("next_data", data, 64'h0017_0016_0015_0014);

        // reset in the middle of a fetch
        clear_mon();
        ram_wait = 1;
        addr = 23'h600020;
        read = 1'b1; tick(1);
        read = 1'b0;
        begin
            int n = 0;
            while (ack_log.size() < 2 && n < 50) begin
                tick(1);
                n++;
            end
        end
        chk("midrst_two_acks", 64'(ack_log.size()), 64'd2);
        reset_n = 1'b0;
        #1;
        chk("midrst_ram_req", {63'd0, ram_if.ram_req}, 64'd0);
        chk("midrst_data",    data, 64'd0);
        chk("midrst_busy",    {63'd0, busy}, 64'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        clear_mon();
        ram_wait = 0;
        addr = 23'h600024;
        read = 1'b1; tick(1);
        read = 1'b0;
        wait_idle("postrst", 100);
        tick(2);
        chk_group("postrst", 23'h600024);
        chk("postrst_data", data, 64'h0027_0026_0025_0024);
        chk("postrst_hold", 64'(hold_bad), 64'd0);

        // stray acks while idle change nothing
        clear_mon();
        stray = 1'b1;
        tick(3);
        stray = 1'b0;
        tick(2);
        chk("stray_fetches", 64'(busy_rises), 64'd0);
        chk("stray_ram_req", {63'd0, ram_if.ram_req}, 64'd0);
        chk("stray_busy",    {63'd0, busy}, 64'd0);
        chk("stray_data",    data, 64'h0027_0026_0025_0024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
